// File: rtl/ex1_serial_adder_pkg.sv
// Shared types and default sizing for the digit-serial adder.
package ex1_pkg;

    typedef enum logic [1:0] {
        LOAD,
        ADD,
        DONE
    } ex1_state_t;

    localparam int EX1_WIDTH   = 8;
    localparam int EX1_DIGIT_W = 2;
    localparam int EX1_NDIGITS = EX1_WIDTH / EX1_DIGIT_W;

endpackage

// File: rtl/ex1_serial_adder_if.sv
// Operand/result bundle between a controller and the serial adder.
interface ex1_serial_adder_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Sum;

    modport master (output A, output B, input Sum);
    modport slave  (input A, input B, output Sum);

endinterface

// File: rtl/ex1_serial_adder_digit_adder.sv
// Combinational DIGIT_W-bit ripple-carry adder used for one digit per cycle.
module ex1_digit_adder #(
    parameter int DIGIT_W = 2
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout
);

    logic [DIGIT_W:0] chain;

    assign chain[0] = cin;

    for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ chain[i];
        assign chain[i+1] = (a[i] & b[i]) | (chain[i] & (a[i] ^ b[i]));
    end

    assign cout = chain[DIGIT_W];

endmodule

// File: rtl/ex1_serial_adder.sv
// Digit-serial unsigned adder: loads A/B once after reset, adds DIGIT_W bits per edge.
// Optional macro EX1_SATURATE_EN clamps an overflowing result to all ones.
module ex1_serial_adder
    import ex1_pkg::*;
#(
    parameter int WIDTH   = EX1_WIDTH,
    parameter int DIGIT_W = EX1_DIGIT_W
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Reset,
    input  logic             Clock,
    output logic [WIDTH-1:0] Sum
);

    localparam int NDIGITS = WIDTH / DIGIT_W;
    localparam int CNT_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    ex1_state_t         state;
    ex1_state_t         state_next;
    logic [CNT_W-1:0]   count;
    logic               carry;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   part;
    logic [WIDTH-1:0]   part_next;
    logic [WIDTH-1:0]   sum_next;
    logic [DIGIT_W-1:0] digit_sum;
    logic               digit_cout;
    logic               last_digit;

    ex1_digit_adder #(.DIGIT_W(DIGIT_W)) u_digit (
        .a    (a_sh[DIGIT_W-1:0]),
        .b    (b_sh[DIGIT_W-1:0]),
        .cin  (carry),
        .sum  (digit_sum),
        .cout (digit_cout)
    );

    assign last_digit = (count == CNT_W'(NDIGITS - 1));
    // New digits enter at the top so the first (LSB) digit ends at bit 0.
    assign part_next  = {digit_sum, part[WIDTH-1:DIGIT_W]};

    always_comb begin
        sum_next = part_next;
`ifdef EX1_SATURATE_EN
        if (digit_cout) begin
            sum_next = '1;
        end
`endif
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            LOAD:    state_next = ADD;
            ADD:     if (last_digit) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
            carry <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            part  <= '0;
            Sum   <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    a_sh  <= A;
                    b_sh  <= B;
                    carry <= 1'b0;
                    count <= '0;
                end
                ADD: begin
                    a_sh  <= a_sh >> DIGIT_W;
                    b_sh  <= b_sh >> DIGIT_W;
                    carry <= digit_cout;
                    part  <= part_next;
                    count <= count + 1'b1;
                    if (last_digit) begin
                        Sum <= sum_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex1_serial_adder.sv
// Self-checking bench for ex1_serial_adder against an arithmetic reference model.
// Honours EX1_SATURATE_EN the same way the design does.
module tb_ex1_serial_adder;

    localparam int LATENCY = 5;

    logic Clock;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    ex1_serial_adder_if #(.WIDTH(8)) bus ();

    ex1_serial_adder dut (
        .A     (bus.A),
        .B     (bus.B),
        .Reset (Reset),
        .Clock (Clock),
        .Sum   (bus.Sum)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [7:0] ref_sum(input logic [7:0] a, input logic [7:0] b);
        int total;
        total = int'(a) + int'(b);
`ifdef EX1_SATURATE_EN
        if (total > 255) return 8'hFF;
`endif
        return 8'(total % 256);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full operation: reset, release, check Sum stays 0 until the completing edge, then holds.
    task automatic run_case(input logic [7:0] a, input logic [7:0] b,
                            input bit scramble, input int hold_edges);
        logic [7:0] exp;
        exp = ref_sum(a, b);
        Reset = 1'b0;
        bus.A = a;
        bus.B = b;
        @(negedge Clock);
        check("reset_sum", bus.Sum, 8'h00);
        Reset = 1'b1;
        for (int e = 1; e <= LATENCY; e++) begin
            @(posedge Clock);
            #1;
            if (e == 1 && scramble) begin
                bus.A = 8'($urandom);
                bus.B = 8'($urandom);
            end
            if (e < LATENCY) check("partial_hidden", bus.Sum, 8'h00);
            else             check("result", bus.Sum, exp);
        end
        for (int h = 0; h < hold_edges; h++) begin
            bus.A = 8'($urandom);
            bus.B = 8'($urandom);
            @(posedge Clock);
            #1;
            check("done_hold", bus.Sum, exp);
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        Reset = 1'b0;
        bus.A = '0;
        bus.B = '0;
        repeat (2) @(negedge Clock);
        check("power_on_reset", bus.Sum, 8'h00);

        run_case(8'h00, 8'h00, 1'b0, 0);
        run_case(8'h00, 8'hFF, 1'b0, 0);
        run_case(8'hB7, 8'h0D, 1'b0, 0);
        run_case(8'h42, 8'h21, 1'b0, 0);
        run_case(8'h01, 8'h80, 1'b0, 0);
        run_case(8'hFF, 8'h01, 1'b0, 0);
        run_case(8'h80, 8'h80, 1'b0, 0);
        run_case(8'h5A, 8'hC3, 1'b1, 22);

        // Asynchronous clear from DONE without waiting for a clock edge.
        #2;
        Reset = 1'b0;
        #1;
        check("async_clear_done", bus.Sum, 8'h00);

        // Abort mid-ADD on the 3rd edge; no stale result may appear afterwards.
        bus.A = 8'hFF;
        bus.B = 8'hFF;
        @(negedge Clock);
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        check("abort_mid_add", bus.Sum, 8'h00);
        for (int k = 0; k < 4; k++) begin
            @(posedge Clock);
            #1;
            check("abort_no_update", bus.Sum, 8'h00);
        end
        run_case(8'h13, 8'h24, 1'b0, 0);

        for (int n = 0; n < 12; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_case(ra, rb, n[0], 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex1_serial_adder.md
# ex1_serial_adder

Digit-serial 8-bit unsigned adder (module `ex1_serial_adder`).
- Captures operands A and B on the first clock after reset release and adds them two bits per cycle, LSB digit first.
- Presents the registered sum on Sum once all digits are done, then holds it until the next reset.
- Sits as a small arithmetic leaf under a controller that pulses reset to start each new addition.

## Interface
- Clock and reset: one clock; reset is asynchronous and active-low. The ports are named `Clock` and `Reset`, as the codebase does.
- Parameter `WIDTH`, default 8: operand and result width. Must be a multiple of `DIGIT_W`.
- Parameter `DIGIT_W`, default 2: bits processed per cycle.
- Port `Clock`, input, 1: rising-edge clock.
- Port `Reset`, input, 1: asynchronous, active-low. Low clears all state; high lets a new addition start.
- Port `A`, input, WIDTH: operand A, unsigned.
- Port `B`, input, WIDTH: operand B, unsigned.
- Port `Sum`, output, WIDTH: registered result, (A+B) mod 2^WIDTH.
- Port order is fixed for positional instantiation: A, B, Reset, Clock, Sum.

## Operation
- States: LOAD, ADD, DONE.
- Reset low, asynchronously:
  - state = LOAD, digit counter = 0, carry = 0;
  - operand shift registers = 0, partial-result register = 0, Sum = 0.
- LOAD, first rising edge with Reset high:
  - capture A and B into operand shift registers; carry = 0; go to ADD.
- ADD, one digit per edge, for WIDTH/DIGIT_W edges:
  - add the low `DIGIT_W` bits of both operand registers plus carry;
  - shift the digit sum into the partial-result register from the MSB side;
  - shift both operand registers right by `DIGIT_W`; update carry; increment counter.
  - After the last digit, load Sum from the completed partial result and go to DONE.
- DONE: hold Sum indefinitely. Changes on A or B are ignored; only reset starts a new operation.
- A and B are sampled only at the LOAD edge; changing them during ADD has no effect.
- Overflow wraps modulo 2^WIDTH; the final carry is discarded unless the configuration feature is enabled.
- Sum never shows partial results: it is 0 from reset until the completing edge.

## Timing
- Latency: 1 + WIDTH/DIGIT_W rising edges after Reset goes high. This is 5 edges for defaults; Sum is valid after the 5th edge.
- With a 10 ns clock, Sum is valid within 50 ns of reset release.
- Reset asserted mid-ADD aborts immediately and asynchronously: Sum = 0, state = LOAD. No partial result is retained.
- Reset release is treated as synchronous by the internal logic; the first usable edge is the first rising edge with Reset sampled high.
- Sum changes exactly once per operation: 0 to result on the completing edge. It also returns to 0 on reset assertion.

## Configuration
- `EX1_SATURATE_EN`:
  - Defined: if the final carry is 1, Sum = all ones (e.g. FF+01 -> FF).
  - Undefined (default): Sum wraps (FF+01 -> 00).
- Latency is identical in both modes.

## Structure
- Package `ex1_pkg` holds:
  - state enum `ex1_state_t` {LOAD, ADD, DONE};
  - default constants `EX1_WIDTH = 8` and `EX1_DIGIT_W = 2`;
  - derived `EX1_NDIGITS = 4`.
- Sub-module `ex1_digit_adder` (combinational):
  - inputs: DIGIT_W-bit a and b, plus carry-in;
  - outputs: DIGIT_W-bit sum and carry-out;
  - implementation: ripple of full adders.
- The top module holds the FSM, counter, shift registers, carry flop and Sum register.

## Test plan
Each case: hold Reset low for at least one cycle, set A/B, raise Reset for 5 edges, then check Sum.
- Reset behaviour: Reset low with any A/B -> Sum = 00 asynchronously, including mid-ADD (assert on the 3rd edge -> Sum 00, no later update).
- Zero and full-scale:
  - A=00, B=00 -> Sum=00 after the 5th edge;
  - A=00, B=FF -> Sum=FF;
  - Sum must be 00 after edges 1–4.
- Carry propagation across digits:
  - A=B7, B=0D -> C4;
  - A=42, B=21 -> 63;
  - A=01, B=80 -> 81.
- Overflow: A=FF, B=01 -> 00 by default; FF with `EX1_SATURATE_EN`. Also A=80, B=80 -> 00 / FF.
- Operand isolation:
  - change A/B after the LOAD edge -> result still reflects the captured values;
  - in DONE, Sum holds for 20+ edges despite input changes.
